ring_route_interlock: RTL and testbench

- Sequential, parametrised successor to the fixed 8-input combinational route interlock.
- Holds per-route lock state for N_ROUTES routes on the ring.
- Grants route requests one per cycle via a round-robin arbiter, against a programmable symmetric conflict matrix.
- Enforces a timed release (time-locking) before a freed route's conflicts may be granted. Sits between route-request logic and signal/point drive outputs.

---
 rtl/ring_interlock_pkg.sv | 29 ++
 rtl/ring_route_interlock_slot.sv | 50 +++++
 rtl/ring_route_interlock.sv | 116 +++++++++++
 tb/tb_ring_route_interlock.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_interlock_pkg.sv
// Shared types and helpers for the ring route interlock: route states and
// conflict-map construction for ring topologies.
package ring_interlock_pkg;

   localparam int unsigned MAX_ROUTES = 32;
   localparam int unsigned MAX_MAP_W  = MAX_ROUTES * MAX_ROUTES;

   // Ring-neighbour conflict map for eight routes (route i vs i+-1 mod 8).
   localparam logic [63:0] RING_MAP_8 = 64'h41A0_5028_140A_0582;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PENDING   = 2'd1,
      LOCKED    = 2'd2,
      RELEASING = 2'd3
   } route_state_t;

   // Builds a map where each route conflicts with its two ring neighbours.
   function automatic logic [MAX_MAP_W-1:0] ring_conflict_map(input int unsigned n);
      logic [MAX_MAP_W-1:0] map;
      map = '0;
      for (int unsigned i = 0; i < n; i++) begin
         map[i*n + ((i + 1) % n)]     = 1'b1;
         map[i*n + ((i + n - 1) % n)] = 1'b1;
      end
      return map;
   endfunction

endpackage

// File: rtl/ring_route_interlock_slot.sv
// Per-route lock state machine with time-locked release.
module route_slot
   import ring_interlock_pkg::*;
#(
   parameter int unsigned RELEASE_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req,
   input  logic         rel,
   input  logic         estop,
   input  logic         win,
   output route_state_t state
);

   localparam int unsigned TW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
   localparam logic [TW-1:0] TLOAD = TW'(RELEASE_CYCLES - 1);

   logic [TW-1:0] timer;

   // Cancel/estop take priority over a grant so a withdrawn request never locks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req && !estop) state <= PENDING;
            end
            PENDING: begin
               if (!req || estop) state <= IDLE;
               else if (win)      state <= LOCKED;
            end
            LOCKED: begin
               if (rel || estop) begin
                  state <= RELEASING;
                  timer <= TLOAD;
               end
            end
            RELEASING: begin
               if (timer == '0) state <= IDLE;
               else             timer <= timer - TW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ring_route_interlock.sv
// Route interlock for a ring: per-route lock slots, conflict-based eligibility
// and a single-grant round-robin arbiter.
module ring_route_interlock
   import ring_interlock_pkg::*;
#(
   parameter int unsigned                  N_ROUTES       = 8,
   parameter logic [N_ROUTES*N_ROUTES-1:0] CONFLICT_MAP   = RING_MAP_8,
   parameter int unsigned                  RELEASE_CYCLES = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [N_ROUTES-1:0]         i_req,
   input  logic [N_ROUTES-1:0]         i_release,
   input  logic                        i_estop,
   output logic [N_ROUTES-1:0]         o_locked,
   output logic [N_ROUTES-1:0]         o_pending,
   output logic [N_ROUTES-1:0]         o_releasing,
   output logic [N_ROUTES-1:0]         o_blocked,
   output logic                        o_grant_vld,
   output logic [$clog2(N_ROUTES)-1:0] o_grant_id
);

   localparam int unsigned IDW = $clog2(N_ROUTES);

   route_state_t        st [N_ROUTES];
   logic [N_ROUTES-1:0] busy;
   logic [N_ROUTES-1:0] elig;
   logic [N_ROUTES-1:0] cand;
   logic [N_ROUTES-1:0] win_vec;
   logic [IDW-1:0]      ptr_q;
   logic [IDW-1:0]      win_idx;
   logic                win_found;

   for (genvar g = 0; g < N_ROUTES; g++) begin : g_slot
      route_slot #(
         .RELEASE_CYCLES (RELEASE_CYCLES)
      ) u_slot (
         .clk   (i_clk),
         .rst_n (i_rst_n),
         .req   (i_req[g]),
         .rel   (i_release[g]),
         .estop (i_estop),
         .win   (win_vec[g]),
         .state (st[g])
      );
   end

   // State decodes.
   always_comb begin
      o_locked    = '0;
      o_pending   = '0;
      o_releasing = '0;
      for (int unsigned i = 0; i < N_ROUTES; i++) begin
         o_locked[i]    = (st[i] == LOCKED);
         o_pending[i]   = (st[i] == PENDING);
         o_releasing[i] = (st[i] == RELEASING);
      end
   end

   assign busy = o_locked | o_releasing;

   // Conflicts are symmetric: either direction of the map counts; diagonal ignored.
   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < N_ROUTES; i++) begin
         elig[i] = o_pending[i];
         for (int unsigned j = 0; j < N_ROUTES; j++) begin
            if ((j != i) && busy[j] &&
                (CONFLICT_MAP[i*N_ROUTES + j] || CONFLICT_MAP[j*N_ROUTES + i]))
               elig[i] = 1'b0;
         end
      end
   end

   assign o_blocked = o_pending & ~elig;

   // A route dropping its request this cycle is leaving PENDING, so it is not offered.
   assign cand = i_estop ? '0 : (elig & i_req);

   // Round-robin search starting at the pointer, wrapping modulo N_ROUTES.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 0; k < N_ROUTES; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= N_ROUTES) idx = idx - N_ROUTES;
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_idx   = IDW'(idx);
         end
      end
   end

   always_comb begin
      win_vec = '0;
      if (win_found) win_vec[win_idx] = 1'b1;
   end

   // Grant registers and round-robin pointer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q       <= '0;
         o_grant_vld <= 1'b0;
         o_grant_id  <= '0;
      end else begin
         o_grant_vld <= win_found;
         if (win_found) begin
            o_grant_id <= win_idx;
            ptr_q      <= (32'(win_idx) == N_ROUTES - 1) ? '0 : win_idx + IDW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ring_route_interlock.sv
// Self-checking bench for ring_route_interlock (8 routes, ring map, 4-cycle release).
module tb_ring_route_interlock;

   localparam int unsigned N  = 8;
   localparam int          RC = 4;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [7:0] i_req;
   logic [7:0] i_release;
   logic       i_estop;
   logic [7:0] o_locked;
   logic [7:0] o_pending;
   logic [7:0] o_releasing;
   logic [7:0] o_blocked;
   logic       o_grant_vld;
   logic [2:0] o_grant_id;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   ring_route_interlock #(
      .N_ROUTES       (8),
      .RELEASE_CYCLES (4)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req       (i_req),
      .i_release   (i_release),
      .i_estop     (i_estop),
      .o_locked    (o_locked),
      .o_pending   (o_pending),
      .o_releasing (o_releasing),
      .o_blocked   (o_blocked),
      .o_grant_vld (o_grant_vld),
      .o_grant_id  (o_grant_id)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: per-route flags plus a countdown of remaining release cycles.
   bit m_lock [N];
   bit m_pend [N];
   int m_left [N];
   int m_ptr;
   bit m_gvld;
   int m_gid;

   function automatic bit nbr(input int a, input int b);
      return (a != b) && ((((a + 1) % N) == b) || (((b + 1) % N) == a));
   endfunction

   function automatic logic [7:0] m_elig();
      logic [7:0] e;
      e = '0;
      for (int i = 0; i < N; i++) begin
         e[i] = m_pend[i];
         for (int j = 0; j < N; j++)
            if (nbr(i, j) && (m_lock[j] || m_left[j] > 0)) e[i] = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [7:0] m_vec(input int which);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         case (which)
            0:       v[i] = m_lock[i];
            1:       v[i] = m_pend[i];
            default: v[i] = (m_left[i] > 0);
         endcase
      return v;
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < N; i++) begin
         m_lock[i] = 0; m_pend[i] = 0; m_left[i] = 0;
      end
      m_ptr = 0; m_gvld = 0; m_gid = 0;
   endtask

   task automatic mdl_step(input logic [7:0] req, input logic [7:0] rel, input logic estop);
      logic [7:0] el;
      int w;
      el = m_elig();
      w  = -1;
      if (!estop)
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (w < 0 && el[idx] && req[idx]) w = idx;
         end
      for (int i = 0; i < N; i++) begin
         if (m_pend[i]) begin
            if (!req[i] || estop) m_pend[i] = 0;
            else if (w == i) begin m_pend[i] = 0; m_lock[i] = 1; end
         end else if (m_lock[i]) begin
            if (rel[i] || estop) begin m_lock[i] = 0; m_left[i] = RC; end
         end else if (m_left[i] > 0) begin
            m_left[i]--;
         end else if (req[i] && !estop) begin
            m_pend[i] = 1;
         end
      end
      m_gvld = (w >= 0);
      if (w >= 0) begin
         m_gid = w;
         m_ptr = (w + 1) % N;
      end
   endtask

   // Called at a falling edge; inputs held for one cycle, returns at the next falling edge.
   task automatic step(input logic [7:0] req, input logic [7:0] rel, input logic estop);
      i_req = req; i_release = rel; i_estop = estop;
      @(posedge i_clk);
      mdl_step(req, rel, estop);
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0; i_req = '0; i_release = '0; i_estop = 1'b0;
      mdl_reset();
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   function automatic logic [63:0] all_out();
      return {28'h0, o_locked, o_pending, o_releasing, o_blocked, o_grant_vld, o_grant_id};
   endfunction

   typedef struct {
      logic       pre_rst;
      logic [7:0] req;
      logic [7:0] rel;
      logic       estop;
      logic [7:0] e_lock;
      logic [7:0] e_pend;
      logic [7:0] e_rel;
      logic [7:0] e_blk;
      logic       e_gvld;
      logic [2:0] e_gid;
   } vec_t;

   vec_t vecs [14];

   initial begin
      logic [7:0] rq;
      logic [7:0] rl;
      logic       es;

      // Single grant, conflict + time-lock, then parallel non-conflicting grants.
      vecs[0]  = '{1, 8'h04, 8'h00, 0, 8'h00, 8'h04, 8'h00, 8'h00, 0, 3'd0};
      vecs[1]  = '{0, 8'h04, 8'h00, 0, 8'h04, 8'h00, 8'h00, 8'h00, 1, 3'd2};
      vecs[2]  = '{0, 8'h08, 8'h00, 0, 8'h04, 8'h08, 8'h00, 8'h08, 0, 3'd0};
      vecs[3]  = '{0, 8'h08, 8'h04, 0, 8'h00, 8'h08, 8'h04, 8'h08, 0, 3'd0};
      vecs[4]  = '{0, 8'h08, 8'h00, 0, 8'h00, 8'h08, 8'h04, 8'h08, 0, 3'd0};
      vecs[5]  = '{0, 8'h08, 8'h00, 0, 8'h00, 8'h08, 8'h04, 8'h08, 0, 3'd0};
      vecs[6]  = '{0, 8'h08, 8'h00, 0, 8'h00, 8'h08, 8'h04, 8'h08, 0, 3'd0};
      vecs[7]  = '{0, 8'h08, 8'h00, 0, 8'h00, 8'h08, 8'h00, 8'h00, 0, 3'd0};
      vecs[8]  = '{0, 8'h08, 8'h00, 0, 8'h08, 8'h00, 8'h00, 8'h00, 1, 3'd3};
      vecs[9]  = '{1, 8'h15, 8'h00, 0, 8'h00, 8'h15, 8'h00, 8'h00, 0, 3'd0};
      vecs[10] = '{0, 8'h15, 8'h00, 0, 8'h01, 8'h14, 8'h00, 8'h00, 1, 3'd0};
      vecs[11] = '{0, 8'h15, 8'h00, 0, 8'h05, 8'h10, 8'h00, 8'h00, 1, 3'd2};
      vecs[12] = '{0, 8'h15, 8'h00, 0, 8'h15, 8'h00, 8'h00, 8'h00, 1, 3'd4};
      vecs[13] = '{0, 8'h15, 8'h00, 0, 8'h15, 8'h00, 8'h00, 8'h00, 0, 3'd0};

      // Reset held with all requests high, then asynchronous reset mid-release.
      i_rst_n = 1'b0; i_req = 8'hFF; i_release = '0; i_estop = 1'b0;
      mdl_reset();
      repeat (3) begin
         @(negedge i_clk);
         chk("rst_hold_outputs", all_out(), 64'h0);
      end
      i_req = '0;
      i_rst_n = 1'b1;
      step(8'h04, 8'h00, 0);
      step(8'h04, 8'h00, 0);
      chk("pre_async_locked", 64'(o_locked), 64'h04);
      step(8'h00, 8'h04, 0);
      chk("pre_async_releasing", 64'(o_releasing), 64'h04);
      @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1 chk("async_rst_outputs", all_out(), 64'h0);
      mdl_reset();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (8) step(8'h00, 8'h00, 0);
      chk("no_relock_after_rst", 64'({o_locked, o_releasing, o_pending}), 64'h0);

      // Table-driven rows.
      for (int r = 0; r < 14; r++) begin
         if (vecs[r].pre_rst) do_reset();
         step(vecs[r].req, vecs[r].rel, vecs[r].estop);
         chk($sformatf("row%0d_locked", r),    64'(o_locked),    64'(vecs[r].e_lock));
         chk($sformatf("row%0d_pending", r),   64'(o_pending),   64'(vecs[r].e_pend));
         chk($sformatf("row%0d_releasing", r), 64'(o_releasing), 64'(vecs[r].e_rel));
         chk($sformatf("row%0d_blocked", r),   64'(o_blocked),   64'(vecs[r].e_blk));
         chk($sformatf("row%0d_grant_vld", r), 64'(o_grant_vld), 64'(vecs[r].e_gvld));
         if (vecs[r].e_gvld) chk($sformatf("row%0d_grant_id", r), 64'(o_grant_id), 64'(vecs[r].e_gid));
      end

      // Round-robin between conflicting routes 0 and 1 with pointer at 1.
      do_reset();
      step(8'h01, 8'h00, 0);
      step(8'h01, 8'h00, 0);
      chk("rr_setup_grant", 64'({o_grant_vld, o_grant_id}), 64'({1'b1, 3'd0}));
      step(8'h00, 8'h01, 0);
      repeat (RC) step(8'h00, 8'h00, 0);
      chk("rr_setup_idle", 64'({o_locked, o_pending, o_releasing}), 64'h0);
      step(8'h03, 8'h00, 0);
      chk("rr_both_pending", 64'({o_pending, o_blocked}), 64'h0300);
      step(8'h03, 8'h00, 0);
      chk("rr_route1_wins", 64'({o_locked, o_grant_vld, o_grant_id}), 64'({8'h02, 1'b1, 3'd1}));
      chk("rr_route0_blocked", 64'(o_blocked), 64'h01);
      step(8'h01, 8'h02, 0);
      repeat (RC) step(8'h01, 8'h00, 0);
      chk("rr_route0_still_pending", 64'({o_locked, o_pending}), 64'h0001);
      step(8'h01, 8'h00, 0);
      chk("rr_route0_granted", 64'({o_locked, o_grant_vld, o_grant_id}), 64'({8'h01, 1'b1, 3'd0}));
      step(8'h29, 8'h00, 0);
      step(8'h29, 8'h00, 0);
      chk("rr_ptr1_picks_3", 64'({o_grant_vld, o_grant_id}), 64'({1'b1, 3'd3}));
      step(8'h29, 8'h00, 0);
      chk("rr_then_5", 64'({o_grant_vld, o_grant_id}), 64'({1'b1, 3'd5}));

      // Emergency stop with routes 0 and 4 locked and route 6 pending.
      do_reset();
      step(8'h11, 8'h00, 0);
      step(8'h11, 8'h00, 0);
      step(8'h11, 8'h00, 0);
      chk("es_locked_0_4", 64'(o_locked), 64'h11);
      step(8'h51, 8'h00, 0);
      chk("es_route6_pending", 64'(o_pending), 64'h40);
      step(8'h51, 8'h00, 1);
      chk("es_after_stop", 64'({o_locked, o_pending, o_releasing, 7'h0, o_grant_vld}), 64'h0000_1100);
      for (int c = 1; c < RC; c++) begin
         step(8'h00, 8'h00, 0);
         chk($sformatf("es_releasing_%0d", c), 64'(o_releasing), 64'h11);
      end
      step(8'h00, 8'h00, 0);
      chk("es_release_done", 64'(o_releasing), 64'h00);
      step(8'hFF, 8'h00, 1);
      step(8'hFF, 8'h00, 1);
      chk("es_held_no_pending", 64'({o_pending, o_locked, 7'h0, o_grant_vld}), 64'h0);

      // Randomised run against the reference model.
      do_reset();
      rq = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 4) == 0) rq[b] = ~rq[b];
         for (int b = 0; b < N; b++)
            rl[b] = ($urandom_range(0, 5) == 0);
         es = ($urandom_range(0, 39) == 0);
         step(rq, rl, es);
         chk($sformatf("rnd%0d_locked", cyc),    64'(o_locked),    64'(m_vec(0)));
         chk($sformatf("rnd%0d_pending", cyc),   64'(o_pending),   64'(m_vec(1)));
         chk($sformatf("rnd%0d_releasing", cyc), 64'(o_releasing), 64'(m_vec(2)));
         chk($sformatf("rnd%0d_blocked", cyc),   64'(o_blocked),   64'(m_vec(1) & ~m_elig()));
         chk($sformatf("rnd%0d_grant_vld", cyc), 64'(o_grant_vld), 64'(m_gvld));
         if (m_gvld) chk($sformatf("rnd%0d_grant_id", cyc), 64'(o_grant_id), 64'(m_gid));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
